// File: rtl/decode_pipe.sv
// RV32 decode stage: combinational decode at the input, decoded entries held in
// a small circular FIFO, head entry presented on the out_* ports.
module decode_pipe #(
  parameter int XLEN         = 32,
  parameter int BUF_DEPTH    = 2,
  parameter int SUPPORT_JUMP = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [6:0]                 out_opcode,
  output logic [2:0]                 out_funct3,
  output logic [6:0]                 out_funct7,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [4:0]                 out_rd,
  output logic [XLEN-1:0]            out_imm,
  output logic [7:0]                 out_ctrl,
  output logic [1:0]                 out_alu_op,
  output logic [1:0]                 out_lw_sw,
  output logic [$clog2(BUF_DEPTH):0] count
);

  localparam int            AW      = $clog2(BUF_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(BUF_DEPTH);
  localparam bit            JUMP_EN = (SUPPORT_JUMP != 0);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [7:0] CTRL_ILL   = 8'b0000_0001;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [7:0]      ctrl;
    logic [1:0]      alu_op;
    logic [1:0]      lw_sw;
  } entry_t;

  entry_t        dec;
  entry_t        head;
  entry_t        mem_q [BUF_DEPTH];
  entry_t        mem_d [BUF_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
  logic          push, pop;

  // Decode the incoming word into a complete FIFO entry
  always_comb begin
    imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    imm_u = {in_instr[31:12], 12'b0};
    imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    dec        = '0;
    dec.pc     = in_pc;
    dec.instr  = in_instr;
    dec.ctrl   = CTRL_ILL;
    // Every legal opcode ends in 2'b11, so a full 7-bit match also covers the
    // instr[1:0] legality test; unmatched words fall through as illegal.
    case (in_instr[6:0])
      OPC_R:      begin dec.ctrl = 8'h80; dec.alu_op = 2'b10; end
      OPC_IALU:   begin dec.ctrl = 8'hC0; dec.alu_op = 2'b10; dec.imm = XLEN'($signed(imm_i)); end
      OPC_LOAD:   begin dec.ctrl = 8'hD4; dec.lw_sw = 2'b10; dec.imm = XLEN'($signed(imm_i)); end
      OPC_STORE:  begin dec.ctrl = 8'h48; dec.lw_sw = 2'b01; dec.imm = XLEN'($signed(imm_s)); end
      OPC_BRANCH: begin dec.ctrl = 8'h20; dec.alu_op = 2'b01; dec.imm = XLEN'($signed(imm_b)); end
      OPC_LUI, OPC_AUIPC: begin
        if (JUMP_EN) begin dec.ctrl = 8'hC0; dec.alu_op = 2'b11; dec.imm = XLEN'($signed(imm_u)); end
      end
      OPC_JAL: begin
        if (JUMP_EN) begin dec.ctrl = 8'h82; dec.imm = XLEN'($signed(imm_j)); end
      end
      OPC_JALR: begin
        if (JUMP_EN) begin dec.ctrl = 8'hC2; dec.imm = XLEN'($signed(imm_i)); end
      end
      default: ;
    endcase
  end

  assign in_ready  = (count_q < DEPTH_C) & ~flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready & ~flush;

  // FIFO next state: flush overrides both push and pop
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = dec;
        wptr_d        = wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is cleared too so the head reads zero in reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head       = mem_q[rptr_q];
  assign out_pc     = head.pc;
  assign out_opcode = head.instr[6:0];
  assign out_funct3 = head.instr[14:12];
  assign out_funct7 = head.instr[31:25];
  assign out_rs1    = head.instr[19:15];
  assign out_rs2    = head.instr[24:20];
  assign out_rd     = head.instr[11:7];
  assign out_imm    = head.imm;
  assign out_ctrl   = head.ctrl;
  assign out_alu_op = head.alu_op;
  assign out_lw_sw  = head.lw_sw;
  assign count      = count_q;

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning width of the sign-extended immediate and of the PC.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning output buffer entries; legal values are powers of 2, at least 2.
REQ-003 SHALL have parameter SUPPORT_JUMP, default 1, meaning: 1 decodes LUI/AUIPC/JAL/JALR; 0 flags them illegal.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rstn  in  1  reset, asynchronous and active-low.
REQ-006 flush  in  1  discards all buffered entries.
REQ-007 in_valid  in  1  in_instr/in_pc are valid.
REQ-008 in_ready  out  1  block can accept an instruction this cycle.
REQ-009 in_instr  in  32  RV32 instruction word.
REQ-010 in_pc  in  XLEN  PC of in_instr.
REQ-011 out_valid  out  1  head entry is valid.
REQ-012 out_ready  in  1  consumer takes the head entry.
REQ-013 out_pc  out  XLEN  PC of the head entry.
REQ-014 out_opcode  out  7  instr[6:0].
REQ-015 out_funct3  out  3  instr[14:12].
REQ-016 out_funct7  out  7  instr[31:25].
REQ-017 out_rs1  out  5  instr[19:15].
REQ-018 out_rs2  out  5  instr[24:20].
REQ-019 out_rd  out  5  instr[11:7].
REQ-020 out_imm  out  XLEN  sign-extended immediate.
REQ-021 out_ctrl  out  8  {regWrite, aluSrc, branch, memRead, memWrite, memToReg, jump, illegal}, MSB first.
REQ-022 out_alu_op  out  2  ALU op class.
REQ-023 out_lw_sw  out  2  10 = load, 01 = store, 00 = other.
REQ-024 count  out  log2(BUF_DEPTH)+1  number of occupied entries.

Function
REQ-025 SHALL decode combinationally at the input and store the full decoded entry in a BUF_DEPTH-entry circular FIFO; outputs always reflect the head entry.
REQ-026 SHALL accept an instruction when in_valid & in_ready; in_ready = (count < BUF_DEPTH) & !flush, with no same-cycle pass-through when full.
REQ-027 SHALL pop when out_valid & out_ready; out_valid = (count != 0).
REQ-028 SHALL have a latency of 1 cycle: an instruction accepted at edge N into an empty buffer gives out_valid=1 after edge N.
REQ-029 On simultaneous push and pop, count SHALL be unchanged and the read/write pointers SHALL each advance, wrapping modulo BUF_DEPTH.
REQ-030 On flush, count and both pointers SHALL clear at the next edge; no push or pop takes effect in that cycle.
REQ-031 Immediate formats: I = sext(i[31:20]); S = sext({i[31:25],i[11:7]}); B = sext({i[31],i[7],i[30:25],i[11:8],0}); U = {i[31:12],12'b0} sign-extended to XLEN; J = sext({i[31],i[19:12],i[20],i[30:21],0}); all others 0.
REQ-032 Control table (ctrl / alu_op / lw_sw):
 - R 0110011: 10000000 / 10 / 00.
 - I-ALU 0010011: 11000000 / 10 / 00.
 - Load 0000011: 11010100 / 00 / 10.
 - Store 0100011: 01001000 / 00 / 01.
 - Branch 1100011: 00100000 / 01 / 00.
 - LUI 0110111 and AUIPC 0010111: 11000000 / 11 / 00.
 - JAL 1101111: 10000010 / 00 / 00.
 - JALR 1100111: 11000010 / 00 / 00.
REQ-033 Any other opcode, instr[1:0] != 11, or a jump/upper-immediate opcode with SUPPORT_JUMP=0, SHALL give ctrl=00000001, alu_op=00, lw_sw=00, imm=0; the entry SHALL still be queued.
REQ-034 Field outputs (opcode through rd, pc) SHALL pass the raw bits through for every instruction type.

Reset
REQ-035 While rstn=0, asynchronously: count=0, pointers=0, out_valid=0, and all out_* data outputs =0; in_ready=1 after release.

Verification
REQ-036 Reset, then push addi x1,x2,-5 (0xFFB10093) -> next cycle: out_valid=1, rd=1, rs1=2, imm=0xFFFFFFFB, ctrl=0xC0, alu_op=10.
REQ-037 Push sw x5,8(x6) then beq x0,x0,-4, with out_ready=0 -> count=2, in_ready=0; store entry shows imm=8, lw_sw=01, ctrl=0x48.
REQ-038 Full buffer with in_valid=1 and out_ready=1 for 1 cycle -> one pop, no push, count=1; next cycle push+pop -> count stays 1 and the pointers wrap.
REQ-039 Push 0x0000006F (JAL) with SUPPORT_JUMP=0 -> ctrl=0x01; with SUPPORT_JUMP=1 -> ctrl=0x82, imm=0.
REQ-040 Buffer holding 2 entries, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, input not accepted; then assert rstn=0 mid-stream -> outputs zero immediately.
